// File: rtl/cory_unroute2_pkg.sv
// ============================================================================
// cory_unroute2_pkg : shared constants and match helper for the 2x2 return path
// Revision 1.0
// ============================================================================
`default_nettype none

package cory_unroute2_pkg;

    localparam int NUM_PORTS = 2;

    // A target/source pair is routable only when each queue head names the other.
    function automatic logic tag_match(
        input logic tq_empty,
        input logic tq_head,
        input logic sq_empty,
        input logic sq_head,
        input logic src_id,
        input logic tgt_id
    );
        return !tq_empty && (tq_head == src_id) && !sq_empty && (sq_head == tgt_id);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cory_unroute2_tagq.sv
// ============================================================================
// cory_tagq : small synchronous FIFO with combinational head read
// Revision 1.0
// ============================================================================
`default_nettype none

module cory_tagq #(
    parameter int W = 1,
    parameter int D = 4,
    localparam int A = $clog2(D) + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o,
    output logic [A-1:0] cnt_o
);

    localparam int PW = $clog2(D);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [A-1:0]  cnt_q, cnt_d;
    logic          do_push, do_pop;

    // A pop frees the head slot this cycle, so a push into a full queue is legal alongside it.
    always_comb begin
        do_pop  = pop_i & (cnt_q != '0);
        do_push = push_i & ((cnt_q != A'(D)) | do_pop);
        wptr_d  = wptr_q + PW'(do_push);
        rptr_d  = rptr_q + PW'(do_pop);
        cnt_d   = cnt_q + A'(do_push) - A'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == A'(D));
    assign cnt_o   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cory_unroute2.sv
// ============================================================================
// cory_unroute2 : steers in-order target responses back to requesting sources
// Revision 1.0
// ============================================================================
`default_nettype none

module cory_unroute2
    import cory_unroute2_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_q0_v,
    input  logic         i_q0_t,
    input  logic         i_q0_r,
    output logic         o_q0_v,
    output logic         o_q0_r,
    input  logic         i_q1_v,
    input  logic         i_q1_t,
    input  logic         i_q1_r,
    output logic         o_q1_v,
    output logic         o_q1_r,
    input  logic         i_b0_v,
    input  logic [N-1:0] i_b0_d,
    output logic         o_b0_r,
    input  logic         i_b1_v,
    input  logic [N-1:0] i_b1_d,
    output logic         o_b1_r,
    output logic         o_y0_v,
    output logic [N-1:0] o_y0_d,
    input  logic         i_y0_r,
    output logic         o_y1_v,
    output logic [N-1:0] o_y1_d,
    input  logic         i_y1_r
);

    localparam int A = $clog2(D) + 1;

    logic [1:0]   q_v, q_t, q_r, room, fire;
    logic [1:0]   sq_push, sq_pop, sq_din, sq_head, sq_empty, sq_full;
    logic [1:0]   tq_push, tq_pop, tq_din, tq_head, tq_empty, tq_full;
    logic [A-1:0] sq_cnt [NUM_PORTS];
    logic [A-1:0] tq_cnt [NUM_PORTS];
    logic [1:0]   m [NUM_PORTS];   // m[t][s]
    logic         unused_cnt;

    assign q_v = {i_q1_v, i_q0_v};
    assign q_t = {i_q1_t, i_q0_t};
    assign q_r = {i_q1_r, i_q0_r};

    always_comb begin
        for (int t = 0; t < NUM_PORTS; t++) begin
            for (int s = 0; s < NUM_PORTS; s++) begin
                m[t][s] = tag_match(tq_empty[t], tq_head[t], sq_empty[s], sq_head[s],
                                    1'(s), 1'(t));
            end
        end
    end

    assign o_y0_v = (i_b0_v & m[0][0]) | (i_b1_v & m[1][0]);
    assign o_y1_v = (i_b0_v & m[0][1]) | (i_b1_v & m[1][1]);
    assign o_y0_d = m[0][0] ? i_b0_d : (m[1][0] ? i_b1_d : '0);
    assign o_y1_d = m[0][1] ? i_b0_d : (m[1][1] ? i_b1_d : '0);
    assign o_b0_r = (i_y0_r & m[0][0]) | (i_y1_r & m[0][1]);
    assign o_b1_r = (i_y0_r & m[1][0]) | (i_y1_r & m[1][1]);

    assign tq_pop = {i_b1_v & o_b1_r, i_b0_v & o_b0_r};
    assign sq_pop = {o_y1_v & i_y1_r, o_y0_v & i_y0_r};

    // Room counts a same-cycle pop as a free slot; source 0 wins a same-target tie.
    always_comb begin
        for (int s = 0; s < NUM_PORTS; s++) begin
            room[s] = (!sq_full[s] | sq_pop[s]) & (!tq_full[q_t[s]] | tq_pop[q_t[s]]);
        end
        if (q_v[0] && q_v[1] && (q_t[0] == q_t[1])) begin
            room[1] = 1'b0;
        end
    end

    assign fire    = q_v & q_r & room;
    assign o_q0_v  = i_q0_v & room[0];
    assign o_q0_r  = i_q0_r & room[0];
    assign o_q1_v  = i_q1_v & room[1];
    assign o_q1_r  = i_q1_r & room[1];
    assign sq_push = fire;
    assign sq_din  = q_t;

    always_comb begin
        for (int t = 0; t < NUM_PORTS; t++) begin
            tq_push[t] = (fire[0] & (q_t[0] == 1'(t))) | (fire[1] & (q_t[1] == 1'(t)));
            tq_din[t]  = !(fire[0] & (q_t[0] == 1'(t)));
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_q
        cory_tagq #(.W(1), .D(D)) u_sq (
            .clk    (clk),
            .reset_n(reset_n),
            .push_i (sq_push[i]),
            .pop_i  (sq_pop[i]),
            .din_i  (sq_din[i]),
            .dout_o (sq_head[i]),
            .empty_o(sq_empty[i]),
            .full_o (sq_full[i]),
            .cnt_o  (sq_cnt[i])
        );
        cory_tagq #(.W(1), .D(D)) u_tq (
            .clk    (clk),
            .reset_n(reset_n),
            .push_i (tq_push[i]),
            .pop_i  (tq_pop[i]),
            .din_i  (tq_din[i]),
            .dout_o (tq_head[i]),
            .empty_o(tq_empty[i]),
            .full_o (tq_full[i]),
            .cnt_o  (tq_cnt[i])
        );
    end

    assign unused_cnt = ^{sq_cnt[0], sq_cnt[1], tq_cnt[0], tq_cnt[1]};

`ifdef SIM
    always @(posedge clk) begin
        if (reset_n && ((i_b0_v && tq_empty[0]) || (i_b1_v && tq_empty[1]))) begin
            $error("ERROR: response presented with no outstanding request");
            $finish;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cory_unroute2.sv
// ============================================================================
// tb_cory_unroute2 : directed and randomized checks of the 2x2 return router
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cory_unroute2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_q0_v, i_q0_t, i_q0_r, o_q0_v, o_q0_r;
    logic       i_q1_v, i_q1_t, i_q1_r, o_q1_v, o_q1_r;
    logic       i_b0_v, i_b1_v, o_b0_r, o_b1_r;
    logic [7:0] i_b0_d, i_b1_d, o_y0_d, o_y1_d;
    logic       o_y0_v, o_y1_v, i_y0_r, i_y1_r;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         n_deliv = 0;
    logic [7:0] exp_q [2][$];
    logic [7:0] tgt_q [2][$];
    logic [7:0] next_id = 8'h00;

    always #5 clk = ~clk;

    cory_unroute2 #(.N(8), .D(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_q0_v(i_q0_v), .i_q0_t(i_q0_t), .i_q0_r(i_q0_r), .o_q0_v(o_q0_v), .o_q0_r(o_q0_r),
        .i_q1_v(i_q1_v), .i_q1_t(i_q1_t), .i_q1_r(i_q1_r), .o_q1_v(o_q1_v), .o_q1_r(o_q1_r),
        .i_b0_v(i_b0_v), .i_b0_d(i_b0_d), .o_b0_r(o_b0_r),
        .i_b1_v(i_b1_v), .i_b1_d(i_b1_d), .o_b1_r(o_b1_r),
        .o_y0_v(o_y0_v), .o_y0_d(o_y0_d), .i_y0_r(i_y0_r),
        .o_y1_v(o_y1_v), .o_y1_d(o_y1_d), .i_y1_r(i_y1_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_q0_v = 0; i_q0_t = 0; i_q0_r = 0;
        i_q1_v = 0; i_q1_t = 0; i_q1_r = 0;
        i_b0_v = 0; i_b0_d = 8'h00; i_b1_v = 0; i_b1_d = 8'h00;
        i_y0_r = 0; i_y1_r = 0;
    endtask

    task automatic drive_targets(input int pct);
        i_b0_v = (tgt_q[0].size() != 0) && ($urandom_range(0, 99) < pct);
        i_b0_d = (tgt_q[0].size() != 0) ? tgt_q[0][0] : 8'h00;
        i_b1_v = (tgt_q[1].size() != 0) && ($urandom_range(0, 99) < pct);
        i_b1_d = (tgt_q[1].size() != 0) ? tgt_q[1][0] : 8'h00;
    endtask

    // Scoreboard update from handshakes visible this cycle.
    task automatic record();
        if (o_y0_v && i_y0_r) begin
            if (exp_q[0].size() == 0) chk("rnd_y0_spurious", 32'(o_y0_v), 32'd0);
            else begin chk("rnd_y0_order", 32'(o_y0_d), 32'(exp_q[0][0])); void'(exp_q[0].pop_front()); end
            n_deliv++;
        end
        if (o_y1_v && i_y1_r) begin
            if (exp_q[1].size() == 0) chk("rnd_y1_spurious", 32'(o_y1_v), 32'd0);
            else begin chk("rnd_y1_order", 32'(o_y1_d), 32'(exp_q[1][0])); void'(exp_q[1].pop_front()); end
            n_deliv++;
        end
        if (i_b0_v && o_b0_r) void'(tgt_q[0].pop_front());
        if (i_b1_v && o_b1_r) void'(tgt_q[1].pop_front());
        if (i_q0_v && i_q1_v && (i_q0_t == i_q1_t)) chk("rnd_tie", 32'(o_q1_r), 32'd0);
        if (i_q0_v && o_q0_r) begin
            exp_q[0].push_back(next_id); tgt_q[i_q0_t].push_back(next_id); next_id++;
        end
        if (i_q1_v && o_q1_r) begin
            exp_q[1].push_back(next_id); tgt_q[i_q1_t].push_back(next_id); next_id++;
        end
    endtask

    initial begin
        idle();
        reset_n = 0;
        // Reset state
        i_q0_v = 1; i_q0_r = 1; i_b0_v = 1; i_y0_r = 1; i_b1_v = 1; i_y1_r = 1;
        #1;
        chk("rst_y0_v", 32'(o_y0_v), 0);
        chk("rst_y1_v", 32'(o_y1_v), 0);
        chk("rst_b0_r", 32'(o_b0_r), 0);
        chk("rst_b1_r", 32'(o_b1_r), 0);
        chk("rst_q0_v", 32'(o_q0_v), 1);
        chk("rst_q0_r", 32'(o_q0_r), 1);
        idle();
        tick(); tick();
        reset_n = 1;
        tick();

        // 1: single request src0 -> tgt1
        i_q0_v = 1; i_q0_t = 1; i_q0_r = 1; #1;
        chk("t1_q0_r", 32'(o_q0_r), 1);
        tick(); idle();
        i_b1_v = 1; i_b1_d = 8'hA5; i_y0_r = 1; #1;
        chk("t1_y0_v", 32'(o_y0_v), 1);
        chk("t1_y0_d", 32'(o_y0_d), 32'hA5);
        chk("t1_b1_r", 32'(o_b1_r), 1);
        chk("t1_y1_v", 32'(o_y1_v), 0);
        tick();
        i_y1_r = 1; #1;
        chk("t1_empty_b1_r", 32'(o_b1_r), 0);
        chk("t1_empty_y0_v", 32'(o_y0_v), 0);
        idle();

        // 2: ordering across targets for one source
        i_q0_v = 1; i_q0_t = 0; i_q0_r = 1; tick();
        i_q0_t = 1; tick(); idle();
        i_b1_v = 1; i_b1_d = 8'h22; i_y0_r = 1; #1;
        chk("t2_b1_blocked", 32'(o_b1_r), 0);
        chk("t2_y0_blocked", 32'(o_y0_v), 0);
        tick();
        chk("t2_b1_still_blocked", 32'(o_b1_r), 0);
        i_b0_v = 1; i_b0_d = 8'h11; #1;
        chk("t2_y0_first", 32'(o_y0_d), 32'h11);
        chk("t2_b0_r", 32'(o_b0_r), 1);
        chk("t2_b1_r_wait", 32'(o_b1_r), 0);
        tick();
        i_b0_v = 0; #1;
        chk("t2_y0_second_v", 32'(o_y0_v), 1);
        chk("t2_y0_second", 32'(o_y0_d), 32'h22);
        chk("t2_b1_r", 32'(o_b1_r), 1);
        tick(); idle();

        // 3: fill src1 -> tgt0, then pop-and-push at full
        i_q1_v = 1; i_q1_t = 0; i_q1_r = 1;
        for (int k = 0; k < 4; k++) begin
            #1; chk("t3_fill_r", 32'(o_q1_r), 1);
            tick();
        end
        chk("t3_full_r", 32'(o_q1_r), 0);
        chk("t3_full_v", 32'(o_q1_v), 0);
        i_b0_v = 1; i_b0_d = 8'h33; i_y1_r = 1; #1;
        chk("t3_pp_b0_r", 32'(o_b0_r), 1);
        chk("t3_pp_y1_d", 32'(o_y1_d), 32'h33);
        chk("t3_pp_q1_r", 32'(o_q1_r), 1);
        chk("t3_pp_q1_v", 32'(o_q1_v), 1);
        tick();
        i_b0_v = 0; #1;
        chk("t3_still_full", 32'(o_q1_r), 0);
        i_q1_v = 0; i_q1_r = 0; i_b0_v = 1;
        for (int k = 0; k < 4; k++) begin
            #1; chk("t3_drain", 32'(o_y1_v), 1);
            tick();
        end
        chk("t3_drained", 32'(o_b0_r), 0);
        idle();

        // 4: same-target tie
        i_q0_v = 1; i_q0_t = 0; i_q0_r = 1; i_q1_v = 1; i_q1_t = 0; i_q1_r = 1; #1;
        chk("t4_q0_r", 32'(o_q0_r), 1);
        chk("t4_q1_r", 32'(o_q1_r), 0);
        chk("t4_q1_v", 32'(o_q1_v), 0);
        tick();
        i_q0_v = 0; #1;
        chk("t4_q1_next", 32'(o_q1_r), 1);
        tick(); idle();
        i_b0_v = 1; i_b0_d = 8'h44; i_y0_r = 1; i_y1_r = 1; #1;
        chk("t4_y0_first", 32'(o_y0_v), 1);
        chk("t4_y1_not_yet", 32'(o_y1_v), 0);
        tick();
        chk("t4_y1_second", 32'(o_y1_v), 1);
        chk("t4_y1_d", 32'(o_y1_d), 32'h44);
        tick(); idle();

        // 5: cross traffic
        i_q0_v = 1; i_q0_t = 0; i_q0_r = 1; i_q1_v = 1; i_q1_t = 1; i_q1_r = 1; #1;
        chk("t5_q0_r", 32'(o_q0_r), 1);
        chk("t5_q1_r", 32'(o_q1_r), 1);
        tick(); idle();
        i_b0_v = 1; i_b0_d = 8'h55; i_b1_v = 1; i_b1_d = 8'h66; i_y0_r = 1; i_y1_r = 1; #1;
        chk("t5_y0_d", 32'(o_y0_d), 32'h55);
        chk("t5_y1_d", 32'(o_y1_d), 32'h66);
        chk("t5_b0_r", 32'(o_b0_r), 1);
        chk("t5_b1_r", 32'(o_b1_r), 1);
        tick(); idle();

        // 6: random traffic with a reset pulse
        for (int i = 0; i < 10000; i++) begin
            i_q0_v = 1'($urandom_range(0, 1)); i_q0_t = 1'($urandom_range(0, 1));
            i_q0_r = 1'($urandom_range(0, 1));
            i_q1_v = 1'($urandom_range(0, 1)); i_q1_t = 1'($urandom_range(0, 1));
            i_q1_r = 1'($urandom_range(0, 1));
            i_y0_r = 1'($urandom_range(0, 1)); i_y1_r = 1'($urandom_range(0, 1));
            drive_targets(70);
            #1;
            if (i == 5000) begin
                reset_n = 0; i_b0_v = 1; i_b1_v = 1; #1;
                chk("rr_y0_v", 32'(o_y0_v), 0);
                chk("rr_y1_v", 32'(o_y1_v), 0);
                chk("rr_b0_r", 32'(o_b0_r), 0);
                chk("rr_b1_r", 32'(o_b1_r), 0);
                chk("rr_q0_r", 32'(o_q0_r), 32'(i_q0_r));
                chk("rr_q1_r", 32'(o_q1_r),
                    32'(i_q1_r & !(i_q0_v & i_q1_v & (i_q0_t == i_q1_t))));
                tick();
                reset_n = 1;
                for (int s = 0; s < 2; s++) begin
                    exp_q[s].delete();
                    tgt_q[s].delete();
                end
            end else begin
                record();
                tick();
            end
        end

        // Drain everything still outstanding
        i_q0_v = 0; i_q1_v = 0; i_y0_r = 1; i_y1_r = 1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
            drive_targets(100);
            #1;
            record();
            tick();
        end
        chk("drain_src0", 32'(exp_q[0].size()), 0);
        chk("drain_src1", 32'(exp_q[1].size()), 0);
        chk("drain_tgt0", 32'(tgt_q[0].size()), 0);
        chk("drain_tgt1", 32'(tgt_q[1].size()), 0);
        chk("rnd_traffic", 32'(n_deliv > 1000), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
